insn_memory_responder: RTL and testbench

Memory-side responder for the fetch stage's read protocol. It accepts 8-byte-aligned read requests tagged with a bus ID and returns one `bus_read_response` per request after a programmable latency. The 64-bit payload carries two packed instructions. The block sits between a core's fetch stage and a word-addressed instruction store that the bench or a loader preloads through a write port.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/responder_req_fifo.sv | 50 +++++
 rtl/insn_memory_responder.sv | 143 ++++++++++++++
 tb/tb_insn_memory_responder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Bus-level types shared by the fetch stage and its memory-side responder.
package bus_pkg;

  typedef logic [63:0] memory_address_t;
  typedef logic [7:0]  bus_id_t;

  typedef enum logic [1:0] {
    bus_read_request  = 2'd0,
    bus_read_response = 2'd1,
    bus_write_request = 2'd2,
    bus_read_error    = 2'd3
  } bus_packet_type_t;

  // Responder sequencing: pick a request, count down the latency, hold the response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

  // Bus ID = core number in the upper nibble, component type in the lower nibble.
  function automatic bus_id_t createBusID(input logic [3:0] core_id, input logic [3:0] component);
    return {core_id, component};
  endfunction

endpackage

// File: rtl/responder_req_fifo.sv
// Request queue for the instruction responder. Pointers carry one extra wrap bit
// so full and empty fall straight out of a pointer compare.
module responder_req_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] slot_reg [DEPTH];
  logic [PW:0]      wr_ptr_reg;
  logic [PW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign head_data = slot_reg[rd_ptr_reg[PW-1:0]];

  // A pop frees the head slot on the same edge, so a full queue can still take a push then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + {{PW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{PW{1'b0}}, 1'b1};
    end
  end

  // Slot storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) slot_reg[wr_ptr_reg[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/insn_memory_responder.sv
// Memory-side responder for instruction fetch: queues aligned read requests, waits a
// programmable latency, reads a two-instruction word from the local store and holds
// the response until the requester acknowledges it.
module insn_memory_responder
  import bus_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [63:0]                  req_address,
  input  logic [7:0]                   req_bus_id,
  output logic                         rsp_valid,
  input  logic                         rsp_ack,
  output logic [1:0]                   rsp_packet_type,
  output logic [63:0]                  rsp_payload,
  output logic [7:0]                   rsp_bus_id,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_index,
  input  logic [63:0]                  wr_data,
  output logic [31:0]                  stat_reads_served,
  output logic [31:0]                  stat_rsp_stall_cycles
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int ENT_W = 1 + IDX_W + 8;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [IDX_W-1:0] req_index;
  logic             req_oor;
  logic             unused_low_bits;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] head_data;
  logic             head_oor;
  logic [IDX_W-1:0] head_index;
  logic [7:0]       head_bus_id;

  resp_state_t      state_reg;
  logic [3:0]       cnt_reg;
  logic             cur_oor_reg;
  logic [IDX_W-1:0] cur_index_reg;
  logic [7:0]       cur_bus_id_reg;

  logic [63:0]      store_mem [MEM_WORDS];

  // Word index is the address above the byte-in-word bits; anything above the store is an error.
  assign req_index       = req_address[IDX_W+2:3];
  assign req_oor         = |req_address[63:IDX_W+3];
  assign unused_low_bits = ^req_address[2:0];

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready && !reset;
  assign fifo_pop  = !reset && !fifo_empty &&
                     ((state_reg == ST_IDLE) || ((state_reg == ST_RESP) && rsp_ack));

  assign {head_oor, head_index, head_bus_id} = head_data;

  responder_req_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data({req_oor, req_index, req_bus_id}),
    .pop      (fifo_pop),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Preload port; survives reset so a loaded program stays in place.
  always_ff @(posedge clk) begin
    if (wr_en) store_mem[wr_index] <= wr_data;
  end

  // Request sequencer with registered response outputs and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg             <= ST_IDLE;
      cnt_reg               <= '0;
      cur_oor_reg           <= 1'b0;
      cur_index_reg         <= '0;
      cur_bus_id_reg        <= '0;
      rsp_valid             <= 1'b0;
      rsp_payload           <= '0;
      rsp_bus_id            <= '0;
      rsp_packet_type       <= bus_read_response;
      stat_reads_served     <= '0;
      stat_rsp_stall_cycles <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fifo_pop) begin
            cur_oor_reg    <= head_oor;
            cur_index_reg  <= head_index;
            cur_bus_id_reg <= head_bus_id;
            cnt_reg        <= CNT_INIT;
            state_reg      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            // Nonblocking read of the store gives old data on a same-edge preload write.
            rsp_payload     <= cur_oor_reg ? 64'd0 : store_mem[cur_index_reg];
            rsp_packet_type <= cur_oor_reg ? bus_read_error : bus_read_response;
            rsp_bus_id      <= cur_bus_id_reg;
            rsp_valid       <= 1'b1;
            state_reg       <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ack) begin
            rsp_valid         <= 1'b0;
            stat_reads_served <= stat_reads_served + 32'd1;
            if (fifo_pop) begin
              cur_oor_reg    <= head_oor;
              cur_index_reg  <= head_index;
              cur_bus_id_reg <= head_bus_id;
              cnt_reg        <= CNT_INIT;
              state_reg      <= ST_WAIT;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            stat_rsp_stall_cycles <= stat_rsp_stall_cycles + 32'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_memory_responder.sv
// Self-checking bench for insn_memory_responder: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase checked against a timing/content model.
module tb_insn_memory_responder;
  import bus_pkg::*;

  localparam int MEM_WORDS  = 1024;
  localparam int LATENCY    = 3;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_address = '0;
  logic [7:0]  req_bus_id = '0;
  logic        rsp_valid;
  logic        rsp_ack = 1'b0;
  logic [1:0]  rsp_packet_type;
  logic [63:0] rsp_payload;
  logic [7:0]  rsp_bus_id;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_index = '0;
  logic [63:0] wr_data = '0;
  logic [31:0] stat_reads_served;
  logic [31:0] stat_rsp_stall_cycles;

  insn_memory_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_address          (req_address),
    .req_bus_id           (req_bus_id),
    .rsp_valid            (rsp_valid),
    .rsp_ack              (rsp_ack),
    .rsp_packet_type      (rsp_packet_type),
    .rsp_payload          (rsp_payload),
    .rsp_bus_id           (rsp_bus_id),
    .wr_en                (wr_en),
    .wr_index             (wr_index),
    .wr_data              (wr_data),
    .stat_reads_served    (stat_reads_served),
    .stat_rsp_stall_cycles(stat_rsp_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  id;
    logic [1:0]  typ;
    logic [63:0] pay;
  } vec_t;

  typedef struct {
    int          acc;
    logic [63:0] pay;
    logic [7:0]  id;
    logic [1:0]  typ;
    logic        oor;
    int          idx;
  } pend_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] mdl_mem [MEM_WORDS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wr_word(input int idx, input logic [63:0] d);
    wr_en = 1'b1;
    wr_index = 10'(idx);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    mdl_mem[idx] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic read_req(input logic [63:0] addr, input logic [7:0] id, output int lat,
                          output logic [63:0] pay, output logic [7:0] gid,
                          output logic [1:0] typ, output bit ok);
    int a;
    int n;
    req_valid = 1'b1;
    req_address = addr;
    req_bus_id = id;
    tick();
    a = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    ok = rsp_valid;
    lat = cyc - a;
    pay = rsp_payload;
    gid = rsp_bus_id;
    typ = rsp_packet_type;
    if (ok) begin
      rsp_ack = 1'b1;
      tick();
      rsp_ack = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    int          lat;
    logic [63:0] pay;
    logic [7:0]  gid;
    logic [1:0]  typ;
    bit          ok;
    int          e0;
    int          got;
    int          n;
    int          vt [3];
    logic [63:0] qexp [3];
    bit          stable;
    logic [63:0] h_pay;
    logic [7:0]  h_id;
    int          seen;
    pend_t       pq [$];
    pend_t       ent;
    int          last_ack;
    int          m_reads;
    int          m_stalls;
    bit          m_valid;
    bit          m_ready;
    int          hv;
    int          cnt;
    logic [63:0] addr;
    int          w;
    int          widx;
    bit          conflict;
    bit          do_wr;
    logic [63:0] wdat;

    do_reset();
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_payload", rsp_payload, 0);
    chk("reset rsp_bus_id", rsp_bus_id, 0);
    chk("reset rsp_type", rsp_packet_type, bus_read_response);
    chk("reset reads", stat_reads_served, 0);
    chk("reset stalls", stat_rsp_stall_cycles, 0);
    chk("reset req_ready", req_ready, 1);

    // Fill the whole store so every random read has defined data.
    for (int i = 0; i < MEM_WORDS; i++) wr_word(i, {$urandom, $urandom});
    wr_word(0, 64'h0000_0013_0000_0093);
    wr_word(5, 64'h2222_2222_1111_1111);
    wr_word(6, 64'h4444_4444_3333_3333);
    wr_word(7, 64'h6666_6666_5555_5555);
    wr_word(1023, 64'hDEAD_BEEF_CAFE_F00D);

    vecs[0] = '{64'h2C, 8'h13, bus_read_response, 64'h2222_2222_1111_1111};
    vecs[1] = '{64'h28, 8'h07, bus_read_response, 64'h2222_2222_1111_1111};
    vecs[2] = '{64'h2F, 8'hA1, bus_read_response, 64'h2222_2222_1111_1111};
    vecs[3] = '{64'h00, 8'h20, bus_read_response, 64'h0000_0013_0000_0093};
    vecs[4] = '{64'h1FF8, 8'h3F, bus_read_response, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[5] = '{64'h2000, 8'h44, bus_read_error, 64'h0};
    vecs[6] = '{64'h8000_0000_0000_0028, 8'hFE, bus_read_error, 64'h0};

    for (int i = 0; i < 7; i++) begin
      read_req(vecs[i].addr, vecs[i].id, lat, pay, gid, typ, ok);
      chk($sformatf("vec%0d responded", i), ok, 1);
      chk($sformatf("vec%0d latency", i), lat, LATENCY + 1);
      chk($sformatf("vec%0d payload", i), pay, vecs[i].pay);
      chk($sformatf("vec%0d bus_id", i), gid, vecs[i].id);
      chk($sformatf("vec%0d type", i), typ, vecs[i].typ);
      chk($sformatf("vec%0d valid drop", i), rsp_valid, 0);
    end

    // Queue full and pipelined responses.
    do_reset();
    qexp[0] = 64'h2222_2222_1111_1111;
    qexp[1] = 64'h4444_4444_3333_3333;
    qexp[2] = 64'h6666_6666_5555_5555;
    req_valid = 1'b1;
    req_address = 64'h28;
    req_bus_id = 8'h01;
    tick();
    e0 = cyc;
    chk("qf ready after first", req_ready, 1);
    req_address = 64'h30;
    req_bus_id = 8'h02;
    tick();
    chk("qf ready after second", req_ready, 1);
    req_address = 64'h38;
    req_bus_id = 8'h03;
    tick();
    req_valid = 1'b0;
    chk("qf ready low when full", req_ready, 0);
    got = 0;
    n = 0;
    vt[0] = 0; vt[1] = 0; vt[2] = 0;
    while (got < 3 && n < 80) begin
      if (rsp_valid) begin
        vt[got] = cyc;
        chk($sformatf("qf payload %0d", got), rsp_payload, qexp[got]);
        chk($sformatf("qf bus_id %0d", got), rsp_bus_id, 64'(got + 1));
        got++;
        rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    chk("qf response count", got, 3);
    chk("qf first latency", vt[0] - e0, LATENCY + 1);
    chk("qf spacing 1", vt[1] - vt[0], LATENCY + 1);
    chk("qf spacing 2", vt[2] - vt[1], LATENCY + 1);

    // Held response with statistics.
    do_reset();
    req_valid = 1'b1;
    req_address = 64'h1FF8;
    req_bus_id = 8'h55;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    chk("held responded", rsp_valid, 1);
    h_pay = rsp_payload;
    h_id = rsp_bus_id;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_payload !== h_pay || rsp_bus_id !== h_id ||
          rsp_packet_type !== bus_read_response) stable = 1'b0;
    end
    chk("held stable", stable, 1);
    chk("held payload", h_pay, 64'hDEAD_BEEF_CAFE_F00D);
    chk("held stall count", stat_rsp_stall_cycles, 10);
    chk("held reads before ack", stat_reads_served, 0);
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    chk("held reads after ack", stat_reads_served, 1);
    chk("held stall after ack", stat_rsp_stall_cycles, 10);
    chk("held valid drop", rsp_valid, 0);

    // Store write on the same edge as the response read.
    req_valid = 1'b1;
    req_address = 64'h28;
    req_bus_id = 8'h21;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    wr_en = 1'b1;
    wr_index = 10'd5;
    wr_data = 64'hAAAA;
    tick();
    wr_en = 1'b0;
    mdl_mem[5] = 64'hAAAA;
    chk("collide valid", rsp_valid, 1);
    chk("collide old data", rsp_payload, 64'h2222_2222_1111_1111);
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    read_req(64'h28, 8'h22, lat, pay, gid, typ, ok);
    chk("collide reread ok", ok, 1);
    chk("collide new data", pay, 64'hAAAA);

    // Reset during WAIT with one request queued.
    req_valid = 1'b1;
    req_address = 64'h30;
    req_bus_id = 8'h31;
    tick();
    req_address = 64'h38;
    req_bus_id = 8'h32;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    req_valid = 1'b1;
    req_address = 64'h0;
    req_bus_id = 8'h33;
    tick();
    reset = 1'b0;
    req_valid = 1'b0;
    chk("midrst payload", rsp_payload, 0);
    chk("midrst bus_id", rsp_bus_id, 0);
    chk("midrst reads", stat_reads_served, 0);
    chk("midrst stalls", stat_rsp_stall_cycles, 0);
    chk("midrst ready", req_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("midrst no response", seen, 0);
    read_req(64'h30, 8'h34, lat, pay, gid, typ, ok);
    chk("midrst new ok", ok, 1);
    chk("midrst new latency", lat, LATENCY + 1);
    chk("midrst preload intact", pay, 64'h4444_4444_3333_3333);
    chk("midrst new id", gid, 8'h34);

    // Randomized traffic against an arrival-time model.
    do_reset();
    last_ack = -1000;
    m_reads = 0;
    m_stalls = 0;
    for (int k = 0; k < 700; k++) begin
      m_valid = 1'b0;
      cnt = pq.size();
      if (pq.size() > 0) begin
        hv = pq[0].acc + LATENCY + 1;
        if (last_ack + LATENCY > hv) hv = last_ack + LATENCY;
        if (hv <= cyc) m_valid = 1'b1;
        if (hv - LATENCY <= cyc) cnt--;
      end
      m_ready = (cnt < FIFO_DEPTH);
      chk($sformatf("rnd ready c%0d", cyc), req_ready, m_ready);
      chk($sformatf("rnd valid c%0d", cyc), rsp_valid, m_valid);
      if (m_valid && rsp_valid) begin
        chk($sformatf("rnd payload c%0d", cyc), rsp_payload, pq[0].pay);
        chk($sformatf("rnd bus_id c%0d", cyc), rsp_bus_id, pq[0].id);
        chk($sformatf("rnd type c%0d", cyc), rsp_packet_type, pq[0].typ);
      end

      w = $urandom_range(0, 1100);
      addr = (64'(w) << 3) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) addr = {1'b1, 31'($urandom), 32'($urandom)};
      req_valid = (k < 600) && ($urandom_range(0, 1) == 1);
      req_address = addr;
      req_bus_id = 8'($urandom);
      rsp_ack = (k >= 600) || ($urandom_range(0, 9) < 6);
      widx = $urandom_range(0, MEM_WORDS - 1);
      conflict = 1'b0;
      foreach (pq[j]) if (!pq[j].oor && pq[j].idx == widx) conflict = 1'b1;
      do_wr = (k < 600) && !conflict && ($urandom_range(0, 4) == 0);
      wdat = {$urandom, $urandom};
      wr_en = do_wr;
      wr_index = 10'(widx);
      wr_data = wdat;
      tick();
      wr_en = 1'b0;

      if (do_wr) mdl_mem[widx] = wdat;
      if (m_valid && rsp_ack) begin
        void'(pq.pop_front());
        last_ack = cyc;
        m_reads++;
      end else if (m_valid) begin
        m_stalls++;
      end
      if (req_valid && m_ready) begin
        ent.acc = cyc;
        ent.id = req_bus_id;
        ent.oor = ((req_address >> 3) >= 64'(MEM_WORDS));
        ent.idx = ent.oor ? -1 : int'(req_address >> 3);
        ent.pay = ent.oor ? 64'd0 : mdl_mem[ent.idx];
        ent.typ = ent.oor ? bus_read_error : bus_read_response;
        pq.push_back(ent);
      end
    end
    req_valid = 1'b0;
    rsp_ack = 1'b0;
    chk("rnd drained", pq.size(), 0);
    chk("rnd reads served", stat_reads_served, 32'(m_reads));
    chk("rnd stall cycles", stat_rsp_stall_cycles, 32'(m_stalls));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
